// File: rtl/quad_decoder.sv
// Quadrature encoder decoder: synchronises and debounces channels A/B on
// strobe cycles, decodes Gray-code transitions into step/dir pulses and
// maintains a wrapping position counter.
module quad_decoder #(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             strobe,
    input  logic             a,
    input  logic             b,
    output logic [WIDTH-1:0] value,
    output logic             step,
    output logic             dir,
    output logic             error
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] DEB_L = CW'(DEBOUNCE);

    // Channel bit 1 is A, bit 0 is B, so a 2-bit vector reads as {A,B}.
    logic [1:0]          sync1_q, sync1_d;
    logic [1:0]          sync2_q, sync2_d;
    logic [1:0]          s_q, s_d;
    logic [1:0][CW-1:0]  cnt_q, cnt_d;
    logic                primed_q, primed_d;
    logic [WIDTH-1:0]    value_q, value_d;
    logic                step_q, step_d;
    logic                dir_q, dir_d;
    logic                error_q, error_d;
    logic                up;

    // Position of a state along the up sequence 00->01->11->10.
    function automatic logic [1:0] gray_pos(input logic [1:0] s);
        return {s[1], s[1] ^ s[0]};
    endfunction

    // Next-state logic: synchroniser shift, per-channel debounce, decode.
    always_comb begin
        sync1_d  = {a, b};
        sync2_d  = sync1_q;
        s_d      = s_q;
        cnt_d    = cnt_q;
        primed_d = primed_q;
        value_d  = value_q;
        dir_d    = dir_q;
        step_d   = 1'b0;
        error_d  = 1'b0;
        up       = 1'b0;

        if (strobe) begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2_q[i] != s_q[i]) begin
                    if (cnt_q[i] + CW'(1) == DEB_L) begin
                        s_d[i]   = sync2_q[i];
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end

            // Encoder already resting at the stable level: nothing to adopt.
            if (sync2_q == s_q) begin
                primed_d = 1'b1;
            end

            if (s_d != s_q) begin
                primed_d = 1'b1;
                // The first accepted level after reset is adopted silently.
                if (primed_q) begin
                    if ((s_d ^ s_q) == 2'b11) begin
                        error_d = 1'b1;
                    end else begin
                        up      = (gray_pos(s_d) == gray_pos(s_q) + 2'd1);
                        step_d  = 1'b1;
                        dir_d   = up;
                        value_d = up ? value_q + WIDTH'(1) : value_q - WIDTH'(1);
                    end
                end
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            s_q      <= '0;
            cnt_q    <= '0;
            primed_q <= 1'b0;
            value_q  <= '0;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            error_q  <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            s_q      <= s_d;
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            value_q  <= value_d;
            step_q   <= step_d;
            dir_q    <= dir_d;
            error_q  <= error_d;
        end
    end

    assign value = value_q;
    assign step  = step_q;
    assign dir   = dir_q;
    assign error = error_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Testbench for quad_decoder: directed scenarios plus randomized pin activity,
// checked every clock against a behavioural model of the encoder decoder.
module tb_quad_decoder;

    localparam int WIDTH = 8;
    localparam int DEB   = 3;
    localparam int MOD   = 1 << WIDTH;

    logic             clk = 1'b0;
    logic             reset, strobe, a, b;
    logic [WIDTH-1:0] value;
    logic             step, dir, error;

    quad_decoder #(.WIDTH(WIDTH), .DEBOUNCE(DEB)) dut (
        .clk    (clk),
        .reset  (reset),
        .strobe (strobe),
        .a      (a),
        .b      (b),
        .value  (value),
        .step   (step),
        .dir    (dir),
        .error  (error)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int steps_seen = 0;
    int errs_seen  = 0;

    // Behavioural model state.
    logic [1:0] m_pin_d1, m_pin_d2;   // pins as seen 1 and 2 clocks ago
    logic [1:0] m_stable;             // accepted {A,B} levels
    int         m_run [2];            // consecutive disagreeing strobe samples
    bit         m_primed;
    int         m_value;
    bit         m_dir, m_step, m_err;
    // Index along the up cycle 00,01,11,10 for each {A,B} code.
    int         pos_of [4] = '{0, 1, 3, 2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit st);
        logic [1:0] synced, nxt;
        bit         was_primed;
        int         d;
        if (r) begin
            m_pin_d1 = '0; m_pin_d2 = '0; m_stable = '0;
            m_run[0] = 0;  m_run[1] = 0;
            m_primed = 0;  m_value = 0; m_dir = 0; m_step = 0; m_err = 0;
            return;
        end
        m_step = 0;
        m_err  = 0;
        synced = m_pin_d2;
        if (st) begin
            nxt = m_stable;
            was_primed = m_primed;
            for (int ch = 0; ch < 2; ch++) begin
                if (synced[ch] != m_stable[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == DEB) begin
                        nxt[ch]   = synced[ch];
                        m_run[ch] = 0;
                    end
                end else begin
                    m_run[ch] = 0;
                end
            end
            if (synced == m_stable) m_primed = 1;
            if (nxt != m_stable) begin
                if (was_primed) begin
                    d = (pos_of[nxt] - pos_of[m_stable] + 4) % 4;
                    if (d == 2) begin
                        m_err = 1;
                    end else begin
                        m_step  = 1;
                        m_dir   = (d == 1);
                        m_value = (m_value + (d == 1 ? 1 : MOD - 1)) % MOD;
                    end
                end
                m_primed = 1;
            end
            m_stable = nxt;
        end
        m_pin_d2 = m_pin_d1;
        m_pin_d1 = {a, b};
    endtask

    task automatic tick(input bit r, input bit st);
        reset  = r;
        strobe = st;
        @(posedge clk);
        model_edge(r, st);
        #1;
        chk("value", 32'(value), 32'(m_value));
        chk("step",  32'(step),  32'(m_step));
        chk("dir",   32'(dir),   32'(m_dir));
        chk("error", 32'(error), 32'(m_err));
        if (step === 1'b1)  steps_seen++;
        if (error === 1'b1) errs_seen++;
    endtask

    // n strobe periods, each three idle clocks followed by a strobe clock.
    task automatic strobes(input int unsigned n);
        repeat (n) begin
            tick(0, 0); tick(0, 0); tick(0, 0); tick(0, 1);
        end
    endtask

    task automatic walk(input logic [1:0] code);
        {a, b} = code;
        strobes(4);
    endtask

    initial begin
        int s0, e0;
        a = 0; b = 0; reset = 1; strobe = 0;

        // Reset at rest 00, then idle strobes: nothing should happen.
        tick(1, 0); tick(1, 0);
        chk("reset_value", 32'(value), 32'd0);
        chk("reset_dir",   32'(dir),   32'd0);
        steps_seen = 0; errs_seen = 0;
        strobes(10);
        chk("idle_steps", steps_seen, 0);
        chk("idle_errs",  errs_seen,  0);

        // Four up transitions, then four down.
        walk(2'b01); walk(2'b11); walk(2'b10); walk(2'b00);
        chk("up_steps", steps_seen, 4);
        chk("up_value", 32'(value), 32'd4);
        chk("up_dir",   32'(dir),   32'd1);
        walk(2'b10); walk(2'b11); walk(2'b01); walk(2'b00);
        chk("down_value", 32'(value), 32'd0);
        chk("down_dir",   32'(dir),   32'd0);

        // Glitch on A for two strobes: rejected.
        s0 = steps_seen;
        a = 1; strobes(2); a = 0; strobes(3);
        chk("glitch_steps", steps_seen - s0, 0);
        chk("glitch_value", 32'(value), 32'd0);
        // Held for exactly three strobes: accepted (00->10 is a down step).
        a = 1; strobes(3);
        chk("held3_steps", steps_seen - s0, 1);
        chk("held3_value", 32'(value), 32'd255);
        a = 0; strobes(4);
        chk("back_value", 32'(value), 32'd0);

        // Both channels together: error, value untouched, then 11->10 counts up.
        e0 = errs_seen;
        walk(2'b11);
        chk("dual_errs",  errs_seen - e0, 1);
        chk("dual_value", 32'(value), 32'd0);
        walk(2'b10);
        chk("after_err_value", 32'(value), 32'd1);
        walk(2'b00);
        chk("up2_value", 32'(value), 32'd2);

        // Wrap-around both ways.
        walk(2'b10); walk(2'b11); walk(2'b01);
        chk("wrap_down", 32'(value), 32'd255);
        walk(2'b11);
        chk("wrap_up",   32'(value), 32'd0);

        // Reset with encoder resting at 11: first level adopted silently.
        a = 1; b = 1;
        tick(1, 0); tick(1, 0);
        s0 = steps_seen; e0 = errs_seen;
        strobes(4);
        chk("adopt_steps", steps_seen - s0, 0);
        chk("adopt_errs",  errs_seen - e0, 0);
        chk("adopt_value", 32'(value), 32'd0);

        // Reset in the middle of a debounce on A.
        a = 0;
        strobes(2);
        tick(1, 0);
        chk("mid_reset_value", 32'(value), 32'd0);
        strobes(5);

        // Randomized pin activity with sparse strobes and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            int unsigned r = $urandom_range(0, 199);
            if (r == 0)       {a, b} = ~{a, b};
            else if (r < 18)  begin if (r[0]) a = ~a; else b = ~b; end
            tick($urandom_range(0, 499) == 0, $urandom_range(0, 2) == 0);
        end
        // Strobe held high continuously.
        for (int i = 0; i < 1500; i++) begin
            int unsigned r = $urandom_range(0, 99);
            if (r == 0)       {a, b} = ~{a, b};
            else if (r < 8)   begin if (r[0]) a = ~a; else b = ~b; end
            tick(0, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
